gate_resp_checker: RTL and testbench

Self-checking response monitor for the and_nand / or_nor gate pair, at the observing end of the bench's stimulus interface. The bench drives in1/in0 and pulses vec_valid; this block waits a settle window, then compares the four gate outputs against expected values. It accumulates vector/error counts, input-combination coverage and first-failure capture, so benches report pass/fail without manual truth-table inspection.

---
 rtl/gate_resp_checker.sv | 168 ++++++++++++++++
 tb/tb_gate_resp_checker.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// Response checker for the and_nand / or_nor gate pair.
// It captures each applied {in1,in0} vector and waits a settle window.
// It then compares the four observed gate outputs against the truth table.
// It accumulates vector and error counts, input coverage and first-failure data.
module gate_resp_checker #(
   parameter int SETTLE_CYCLES = 5,
   parameter int CNT_W         = 8,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             in0,
   input  logic             in1,
   input  logic             and_out,
   input  logic             nand_out,
   input  logic             or_out,
   input  logic             nor_out,
   output logic             armed,
   output logic             busy,
   output logic             check_done,
   output logic [CNT_W-1:0] vec_count,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       coverage,
   output logic             all_covered,
   output logic             overrun,
   output logic             pass,
   output logic             ff_valid,
   output logic [1:0]       ff_vec,
   output logic [3:0]       ff_obs
);

   typedef enum logic [1:0] {IDLE, ARMED, SETTLE, CHECK} state_t;

   // The compare happens in the last SETTLE cycle, so the counter stops one short of SETTLE_CYCLES.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [1:0]       vec_q, vec_d;
   logic             check_done_q, check_done_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [3:0]       coverage_q, coverage_d;
   logic             overrun_q, overrun_d;
   logic             ff_valid_q, ff_valid_d;
   logic [1:0]       ff_vec_q, ff_vec_d;
   logic [3:0]       ff_obs_q, ff_obs_d;

   logic [3:0]       obs;
   logic [3:0]       expected;
   logic             mismatch;

   // Expected gate outputs come from the captured vector.
   // A live input that drifts away from that vector also counts as a failure.
   always_comb begin
      obs      = {and_out, nand_out, or_out, nor_out};
      expected = {vec_q[1] & vec_q[0], ~(vec_q[1] & vec_q[0]),
                  vec_q[1] | vec_q[0], ~(vec_q[1] | vec_q[0])};
      mismatch = (obs !== expected) || ({in1, in0} != vec_q);
   end

   // Next-state logic: start clears everything and re-arms; otherwise the FSM walks capture/settle/check.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      vec_d        = vec_q;
      check_done_d = 1'b0;
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      coverage_d   = coverage_q;
      overrun_d    = overrun_q;
      ff_valid_d   = ff_valid_q;
      ff_vec_d     = ff_vec_q;
      ff_obs_d     = ff_obs_q;
      if (start) begin
         state_d     = ARMED;
         cnt_d       = '0;
         vec_d       = '0;
         vec_count_d = '0;
         err_count_d = '0;
         coverage_d  = '0;
         overrun_d   = 1'b0;
         ff_valid_d  = 1'b0;
         ff_vec_d    = '0;
         ff_obs_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED: begin
               if (vec_valid) begin
                  state_d = SETTLE;
                  vec_d   = {in1, in0};
                  cnt_d   = '0;
               end
            end
            SETTLE: begin
               if (vec_valid) overrun_d = 1'b1;
               if (cnt_q == SETTLE_LAST) begin
                  state_d      = CHECK;
                  check_done_d = 1'b1;
                  if (vec_count_q != '1) vec_count_d = vec_count_q + CNT_W'(1);
                  coverage_d[vec_q] = 1'b1;
                  if (mismatch) begin
                     if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                     if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = vec_q;
                        ff_obs_d   = obs;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            CHECK: begin
               if (vec_valid) overrun_d = 1'b1;
               state_d = ARMED;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         vec_q        <= '0;
         check_done_q <= 1'b0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         coverage_q   <= '0;
         overrun_q    <= 1'b0;
         ff_valid_q   <= 1'b0;
         ff_vec_q     <= '0;
         ff_obs_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         vec_q        <= vec_d;
         check_done_q <= check_done_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         coverage_q   <= coverage_d;
         overrun_q    <= overrun_d;
         ff_valid_q   <= ff_valid_d;
         ff_vec_q     <= ff_vec_d;
         ff_obs_q     <= ff_obs_d;
      end
   end

   assign armed       = (state_q != IDLE);
   assign busy        = (state_q == SETTLE) || (state_q == CHECK);
   assign check_done  = check_done_q;
   assign vec_count   = vec_count_q;
   assign err_count   = err_count_q;
   assign coverage    = coverage_q;
   assign all_covered = (coverage_q == 4'b1111);
   assign overrun     = overrun_q;
   assign pass        = (vec_count_q != '0) && (err_count_q == '0) && !overrun_q;
   assign ff_valid    = ff_valid_q;
   assign ff_vec      = ff_vec_q;
   assign ff_obs      = ff_obs_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker.
// Two instances share the stimulus: a default one and a narrow-counter one for the saturation case.
// A behavioural model derives the expected results from the gate truth table.
module tb_gate_resp_checker;

   localparam int S = 5;

   logic clk = 1'b0;
   logic reset, start, vec_valid, in0, in1, and_out, nand_out, or_out, nor_out;

   logic       armed, busy, check_done, all_covered, overrun, pass, ff_valid;
   logic [7:0] vec_count, err_count;
   logic [3:0] coverage, ff_obs;
   logic [1:0] ff_vec;

   logic       s_armed, s_busy, s_check_done, s_all_covered, s_overrun, s_pass, s_ff_valid;
   logic [1:0] s_vec_count, s_err_count, s_ff_vec;
   logic [3:0] s_coverage, s_ff_obs;

   logic [28:0] got_big;
   assign got_big = {vec_count, err_count, coverage, overrun, pass, ff_valid, ff_vec, ff_obs};

   gate_resp_checker #(.SETTLE_CYCLES(S), .CNT_W(8), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid), .in0(in0), .in1(in1),
      .and_out(and_out), .nand_out(nand_out), .or_out(or_out), .nor_out(nor_out),
      .armed(armed), .busy(busy), .check_done(check_done), .vec_count(vec_count),
      .err_count(err_count), .coverage(coverage), .all_covered(all_covered), .overrun(overrun),
      .pass(pass), .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_obs(ff_obs));

   gate_resp_checker #(.SETTLE_CYCLES(S), .CNT_W(2), .ERR_W(2)) dut_small (
      .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid), .in0(in0), .in1(in1),
      .and_out(and_out), .nand_out(nand_out), .or_out(or_out), .nor_out(nor_out),
      .armed(s_armed), .busy(s_busy), .check_done(s_check_done), .vec_count(s_vec_count),
      .err_count(s_err_count), .coverage(s_coverage), .all_covered(s_all_covered),
      .overrun(s_overrun), .pass(s_pass), .ff_valid(s_ff_valid), .ff_vec(s_ff_vec),
      .ff_obs(s_ff_obs));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         m_vec, m_err;
   logic [3:0] m_cov;
   logic       m_ov, m_ffv;
   logic [1:0] m_ffvec;
   logic [3:0] m_ffobs;

   function automatic logic [3:0] good(input logic [1:0] v);
      logic a, o;
      a = v[1] && v[0];
      o = v[1] || v[0];
      return {a, !a, o, !o};
   endfunction

   function automatic int sat(input int x, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (x > mx) ? mx : x;
   endfunction

   function automatic logic [28:0] exp_big();
      logic p;
      p = (m_vec != 0) && (m_err == 0) && !m_ov;
      return {8'(sat(m_vec, 8)), 8'(sat(m_err, 8)), m_cov, m_ov, p, m_ffv, m_ffvec, m_ffobs};
   endfunction

   task automatic model_clear();
      m_vec = 0; m_err = 0; m_cov = '0; m_ov = 1'b0;
      m_ffv = 1'b0; m_ffvec = '0; m_ffobs = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      model_clear();
   endtask

   // Applies one vector and waits (bounded) for its check_done.
   // It then updates the model and steps back into ARMED.
   // Returns the latency in cycles from vec_valid, or -1 on timeout.
   task automatic apply_vector(input logic [1:0] v, input logic [3:0] flip, input int chg_at,
                               output int lat);
      logic [3:0] obs;
      logic       mis;
      {in1, in0} = v;
      {and_out, nand_out, or_out, nor_out} = good(v) ^ flip;
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      lat = 1;
      while (!check_done && lat < 40) begin
         if (lat == chg_at) in0 = ~in0;
         step();
         lat++;
      end
      if (check_done) begin
         obs = {and_out, nand_out, or_out, nor_out};
         mis = (obs != good(v)) || ({in1, in0} != v);
         m_vec++;
         m_cov[v] = 1'b1;
         if (mis) begin
            m_err++;
            if (!m_ffv) begin
               m_ffv = 1'b1; m_ffvec = v; m_ffobs = obs;
            end
         end
      end else begin
         lat = -1;
      end
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; vec_valid = 1'b1;
      step();
      step();
      start = 1'b0; vec_valid = 1'b0;
      checks++;
      if (got_big !== 29'd0) begin errors++; $display("[TB] FAIL reset_results got=%h want=0", got_big); end
      checks++;
      if ({armed, busy, check_done, all_covered} !== 4'b0000) begin
         errors++; $display("[TB] FAIL reset_flags got=%b want=0000", {armed, busy, check_done, all_covered});
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_idle_vec();
      {in1, in0} = 2'b11;
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      step();
      checks++;
      if ({armed, busy, overrun} !== 3'b000) begin
         errors++; $display("[TB] FAIL idle_vec got=%b want=000", {armed, busy, overrun});
      end
   endtask

   task automatic test_basic();
      int lat;
      do_start();
      checks++;
      if (armed !== 1'b1) begin errors++; $display("[TB] FAIL start_armed got=%b want=1", armed); end
      for (int v = 0; v < 4; v++) begin
         apply_vector(2'(v), 4'b0000, 0, lat);
         checks++;
         if (lat !== S + 1) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=%0d", lat, S + 1); end
         checks++;
         if (check_done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse got=%b want=0", check_done); end
      end
      checks++;
      if (got_big !== exp_big()) begin errors++; $display("[TB] FAIL basic_results got=%h want=%h", got_big, exp_big()); end
      checks++;
      if ({all_covered, pass, ff_valid, busy} !== 4'b1100) begin
         errors++; $display("[TB] FAIL basic_flags got=%b want=1100", {all_covered, pass, ff_valid, busy});
      end
   endtask

   task automatic test_stuck();
      int lat;
      do_start();
      apply_vector(2'b11, 4'b0000, 0, lat);
      apply_vector(2'b00, 4'b0100, 0, lat);
      checks++;
      if ({err_count, ff_vec, ff_obs, pass} !== {8'd1, 2'b00, 4'b0001, 1'b0}) begin
         errors++; $display("[TB] FAIL stuck_nand got=%h want=%h", {err_count, ff_vec, ff_obs, pass},
                            {8'd1, 2'b00, 4'b0001, 1'b0});
      end
      checks++;
      if (got_big !== exp_big()) begin errors++; $display("[TB] FAIL stuck_results got=%h want=%h", got_big, exp_big()); end
   endtask

   task automatic test_overrun();
      int lat, extra;
      do_start();
      {in1, in0} = 2'b01;
      {and_out, nand_out, or_out, nor_out} = good(2'b01);
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      step();
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      lat = 3;
      while (!check_done && lat < 40) begin step(); lat++; end
      checks++;
      if (lat !== S + 1) begin errors++; $display("[TB] FAIL overrun_latency got=%0d want=%0d", lat, S + 1); end
      m_vec++; m_cov[1] = 1'b1; m_ov = 1'b1;
      extra = 0;
      for (int i = 0; i < 12; i++) begin step(); if (check_done) extra++; end
      checks++;
      if (extra !== 0) begin errors++; $display("[TB] FAIL overrun_extra_done got=%0d want=0", extra); end
      checks++;
      if (got_big !== exp_big()) begin errors++; $display("[TB] FAIL overrun_results got=%h want=%h", got_big, exp_big()); end
      // vec_valid in the CHECK cycle is an overrun too
      do_start();
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      lat = 1;
      while (!check_done && lat < 40) begin step(); lat++; end
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      m_vec++; m_cov[1] = 1'b1; m_ov = 1'b1;
      checks++;
      if ({overrun, busy, armed} !== 3'b101) begin
         errors++; $display("[TB] FAIL check_cycle_overrun got=%b want=101", {overrun, busy, armed});
      end
   endtask

   task automatic test_unstable();
      int lat;
      do_start();
      apply_vector(2'b00, 4'b0000, 3, lat);
      checks++;
      if ({err_count, ff_valid, ff_vec, ff_obs} !== {8'd1, 1'b1, 2'b00, 4'b0101}) begin
         errors++; $display("[TB] FAIL unstable_input got=%h want=%h", {err_count, ff_valid, ff_vec, ff_obs},
                            {8'd1, 1'b1, 2'b00, 4'b0101});
      end
   endtask

   task automatic test_abort();
      int lat, seen;
      do_start();
      apply_vector(2'b10, 4'b0001, 0, lat);
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      step();
      do_start();
      seen = 0;
      for (int i = 0; i < 10; i++) begin if (check_done) seen++; step(); end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL abort_done got=%0d want=0", seen); end
      checks++;
      if ({got_big, armed, busy} !== {29'd0, 1'b1, 1'b0}) begin
         errors++; $display("[TB] FAIL abort_state got=%h want=%h", {got_big, armed, busy}, {29'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      do_start();
      {in1, in0} = 2'b11;
      vec_valid = 1'b1;
      step();
      vec_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_clear();
      checks++;
      if ({got_big, armed, busy, check_done} !== 32'd0) begin
         errors++; $display("[TB] FAIL reset_mid_state got=%h want=0", {got_big, armed, busy, check_done});
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin step(); if (check_done) seen++; end
      checks++;
      if (seen !== 0) begin errors++; $display("[TB] FAIL reset_mid_done got=%0d want=0", seen); end
   endtask

   task automatic test_random();
      int lat;
      logic [1:0] v;
      logic [3:0] flip;
      int chg;
      do_start();
      for (int n = 0; n < 40; n++) begin
         v = 2'($urandom_range(0, 3));
         flip = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         chg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, S)) : 0;
         apply_vector(v, flip, chg, lat);
         checks++;
         if (lat !== S + 1) begin errors++; $display("[TB] FAIL rand_latency got=%0d want=%0d", lat, S + 1); end
         checks++;
         if (got_big !== exp_big()) begin errors++; $display("[TB] FAIL rand_results got=%h want=%h", got_big, exp_big()); end
         checks++;
         if ({s_vec_count, s_err_count} !== {2'(sat(m_vec, 2)), 2'(sat(m_err, 2))}) begin
            errors++; $display("[TB] FAIL rand_small got=%b want=%b", {s_vec_count, s_err_count},
                               {2'(sat(m_vec, 2)), 2'(sat(m_err, 2))});
         end
         repeat ($urandom_range(0, 3)) step();
      end
   endtask

   task automatic test_saturation();
      int lat;
      do_start();
      for (int n = 0; n < 6; n++) apply_vector(2'($urandom_range(0, 3)), 4'b1000, 0, lat);
      checks++;
      if ({vec_count, err_count} !== {8'd6, 8'd6}) begin
         errors++; $display("[TB] FAIL sat_big got=%h want=0606", {vec_count, err_count});
      end
      checks++;
      if ({s_vec_count, s_err_count} !== 4'b1111) begin
         errors++; $display("[TB] FAIL sat_small got=%b want=1111", {s_vec_count, s_err_count});
      end
      do_start();
      checks++;
      if ({s_vec_count, s_err_count, s_coverage, s_ff_valid, s_overrun, s_armed} !== 12'b0000_0000_0001) begin
         errors++; $display("[TB] FAIL sat_clear got=%b want=000000000001",
                            {s_vec_count, s_err_count, s_coverage, s_ff_valid, s_overrun, s_armed});
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; vec_valid = 1'b0; in0 = 1'b0; in1 = 1'b0;
      {and_out, nand_out, or_out, nor_out} = good(2'b00);
      model_clear();
      test_reset();
      test_idle_vec();
      test_basic();
      test_stuck();
      test_overrun();
      test_unstable();
      test_abort();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
